// File: rtl/bus_pkg.sv
// Shared bus definitions used by the CU master and the memory responder.
package bus_pkg;
  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;

  typedef enum logic {
    RESP_OK    = 1'b0,
    RESP_ERROR = 1'b1
  } bus_response_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS
  } responder_state_t;
endpackage

// File: rtl/bus_sram.sv
// Synchronous single-port word memory with byte write enables.
module bus_sram
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = "",
  localparam int unsigned INDEX_W    = $clog2(DEPTH_WORDS)
) (
  input  logic                  clock,
  input  logic                  enable,
  input  logic                  write,
  input  logic [3:0]            strobe,
  input  logic [INDEX_W-1:0]    index,
  input  logic [BUS_DATA_W-1:0] write_data,
  output logic [BUS_DATA_W-1:0] read_data
);
  logic [BUS_DATA_W-1:0] mem [DEPTH_WORDS];

  // read_data only moves on an enabled read, so it holds across writes
  always_ff @(posedge clock) begin
    if (enable) begin
      if (write) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (strobe[b]) mem[index][8*b +: 8] <= write_data[8*b +: 8];
        end
      end else begin
        read_data <= mem[index];
      end
    end
  end
endmodule

// File: rtl/bus_memory_responder.sv
// Bus responder: accepts one request at a time, inserts wait states, serves it from bus_sram.
module bus_memory_responder
  import bus_pkg::*;
#(
  parameter logic [BUS_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned           DEPTH_WORDS = 1024,
  parameter int unsigned           WAIT_STATES = 0,
  parameter string                 INIT_FILE   = ""
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bus_start,
  input  logic                  bus_write,
  input  logic [BUS_ADDR_W-1:0] bus_address,
  input  logic [BUS_DATA_W-1:0] bus_write_data,
  input  logic [3:0]            bus_strobe,
  output logic                  bus_ready,
  output logic [BUS_DATA_W-1:0] bus_read_data,
  output bus_response_t         bus_response
);
  localparam int unsigned INDEX_W = $clog2(DEPTH_WORDS);

  responder_state_t      state;
  logic [3:0]            count;
  logic [BUS_ADDR_W-1:0] address_q;
  logic [BUS_DATA_W-1:0] write_data_q;
  logic [3:0]            strobe_q;
  logic                  write_q;
  logic                  read_ok;
  logic [BUS_ADDR_W-1:0] offset;
  logic                  decode_error;
  logic                  sram_enable;
  logic [BUS_DATA_W-1:0] sram_data;

  // BASE_ADDR is word aligned, so offset[1:0] equals the address's low bits
  always_comb begin
    offset       = address_q - BASE_ADDR;
    decode_error = (offset[1:0] != 2'b00) || (offset[BUS_ADDR_W-1:INDEX_W+2] != '0);
    sram_enable  = (state == ST_ACCESS) && !decode_error;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      bus_ready    <= 1'b1;
      bus_response <= RESP_OK;
      read_ok      <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
      write_q      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus_start) begin
            address_q    <= bus_address;
            write_data_q <= bus_write_data;
            strobe_q     <= bus_strobe;
            write_q      <= bus_write;
            count        <= 4'(WAIT_STATES);
            bus_ready    <= 1'b0;
            state        <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          count <= count - 1'b1;
          if (count == 4'd1) state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          bus_ready <= 1'b1;
          state     <= ST_IDLE;
          if (decode_error) begin
            bus_response <= RESP_ERROR;
            read_ok      <= 1'b0;
          end else begin
            bus_response <= RESP_OK;
            if (!write_q) read_ok <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data lives in the SRAM output register; read_ok forces zero after reset or an error
  assign bus_read_data = read_ok ? sram_data : '0;

  bus_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_sram (
    .clock     (clock),
    .enable    (sram_enable),
    .write     (write_q),
    .strobe    (strobe_q),
    .index     (offset[2 +: INDEX_W]),
    .write_data(write_data_q),
    .read_data (sram_data)
  );
endmodule

// File: tb/tb_bus_memory_responder.sv
// Randomized bench for bus_memory_responder: three configurations checked against an array model.
module tb_bus_memory_responder;
  import bus_pkg::*;

  logic          clock;
  logic          reset;
  logic          start  [3];
  logic          write  [3];
  logic [31:0]   addr   [3];
  logic [31:0]   wdata  [3];
  logic [3:0]    strobe [3];
  logic          ready  [3];
  logic [31:0]   rdata  [3];
  bus_response_t resp   [3];

  logic [31:0] model_mem [3][64];
  logic [31:0] model_rd  [3];

  int unsigned total = 0;
  int unsigned bad   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  bus_memory_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(64), .WAIT_STATES(2), .INIT_FILE("")) u_dut0 (
    .clock(clock), .reset(reset), .bus_start(start[0]), .bus_write(write[0]), .bus_address(addr[0]),
    .bus_write_data(wdata[0]), .bus_strobe(strobe[0]), .bus_ready(ready[0]), .bus_read_data(rdata[0]),
    .bus_response(resp[0]));

  bus_memory_responder #(.BASE_ADDR(32'h0000_0100), .DEPTH_WORDS(64), .WAIT_STATES(1), .INIT_FILE("")) u_dut1 (
    .clock(clock), .reset(reset), .bus_start(start[1]), .bus_write(write[1]), .bus_address(addr[1]),
    .bus_write_data(wdata[1]), .bus_strobe(strobe[1]), .bus_ready(ready[1]), .bus_read_data(rdata[1]),
    .bus_response(resp[1]));

  bus_memory_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(16), .WAIT_STATES(0), .INIT_FILE("")) u_dut2 (
    .clock(clock), .reset(reset), .bus_start(start[2]), .bus_write(write[2]), .bus_address(addr[2]),
    .bus_write_data(wdata[2]), .bus_strobe(strobe[2]), .bus_ready(ready[2]), .bus_read_data(rdata[2]),
    .bus_response(resp[2]));

  function automatic logic [31:0] base_of(input int unsigned i);
    return (i == 1) ? 32'h0000_0100 : 32'h0000_0000;
  endfunction

  function automatic int unsigned depth_of(input int unsigned i);
    return (i == 2) ? 16 : 64;
  endfunction

  function automatic int unsigned ws_of(input int unsigned i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete transaction, with latency, response and read data checked against the model
  task automatic txn(input int unsigned i, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input string tag);
    int unsigned   lat;
    logic [31:0]   off;
    logic [31:0]   w;
    bit            err;
    bus_response_t exp_resp;
    @(negedge clock);
    start[i] = 1'b1; write[i] = wr; addr[i] = a; wdata[i] = d; strobe[i] = s;
    @(posedge clock); #1;
    start[i] = 1'b0; write[i] = 1'($urandom); addr[i] = $urandom; wdata[i] = $urandom; strobe[i] = 4'($urandom);
    lat = 0;
    while (!ready[i] && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    off = a - base_of(i);
    err = (a % 4 != 0) || (off >= depth_of(i) * 4);
    w   = off / 4;
    exp_resp = err ? RESP_ERROR : RESP_OK;
    if (err) model_rd[i] = '0;
    else if (wr) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[i][w][8*b +: 8] = d[8*b +: 8];
    end else model_rd[i] = model_mem[i][w];
    check({tag, "_latency"}, lat, 1 + ws_of(i));
    check({tag, "_resp"}, 32'(resp[i]), 32'(exp_resp));
    check({tag, "_rdata"}, rdata[i], model_rd[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_ready"}, 32'(ready[i]), 32'd1);
      check({tag, "_resp"}, 32'(resp[i]), 32'(RESP_OK));
      check({tag, "_rdata"}, rdata[i], 32'h0);
      model_rd[i] = '0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] off;
    int unsigned r;
    logic [31:0] old;

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; write[i] = 1'b0; addr[i] = '0; wdata[i] = '0; strobe[i] = '0;
    end
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Fill every word so the model is fully known
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < int'(depth_of(i)); w++)
        txn(i, 1'b1, base_of(i) + 32'(4 * w), $urandom, 4'hF, "fill");

    // Wait-state read of word 0
    txn(0, 1'b1, 32'h0, 32'h0000_0013, 4'hF, "w0");
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, "r0");
    check("r0_value", rdata[0], 32'h0000_0013);

    // Byte strobes
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, "wfull");
    txn(0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, "wbyte");
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "rbyte");
    check("rbyte_value", rdata[0], 32'hDEAD_BEAA);
    txn(0, 1'b1, 32'h10, 32'h1234_5678, 4'b0000, "wnone");
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "rnone");

    // Decode errors, and error writes leaving memory intact
    txn(0, 1'b0, 32'h2, 32'h0, 4'h0, "rmis");
    txn(0, 1'b0, 32'h100, 32'h0, 4'h0, "rover");
    txn(0, 1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, "wover");
    txn(0, 1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, "wmis");
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, "rintact0");
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "rintact10");
    txn(1, 1'b0, 32'h0FC, 32'h0, 4'h0, "rbelow");
    txn(1, 1'b0, 32'h100, 32'h0, 4'h0, "rbase");
    txn(1, 1'b0, 32'h1FC, 32'h0, 4'h0, "rtop");
    txn(1, 1'b0, 32'h200, 32'h0, 4'h0, "rpast");

    // Back-to-back reads with bus_start held high
    @(negedge clock);
    start[2] = 1'b1; write[2] = 1'b0; addr[2] = 32'h0; strobe[2] = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      check("b2b_busy", 32'(ready[2]), 32'd0);
      if (k < 3) addr[2] = 32'(4 * (k + 1));
      else start[2] = 1'b0;
      @(posedge clock); #1;
      check("b2b_ready", 32'(ready[2]), 32'd1);
      check("b2b_rdata", rdata[2], model_mem[2][k]);
      check("b2b_resp", 32'(resp[2]), 32'(RESP_OK));
    end
    model_rd[2] = model_mem[2][3];

    // Reset during the wait phase of a write
    old = model_mem[0][8];
    @(negedge clock);
    start[0] = 1'b1; write[0] = 1'b1; addr[0] = 32'h20; wdata[0] = ~old; strobe[0] = 4'hF;
    @(posedge clock); #1;
    start[0] = 1'b0;
    check("abort_busy", 32'(ready[0]), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clock);
    reset = 1'b1;
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, "abort_readback");
    check("abort_value", rdata[0], old);

    // Random mix of reads, writes and decode errors
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 120; n++) begin
        r   = $urandom_range(0, 9);
        off = 32'(4 * $urandom_range(0, depth_of(i) - 1));
        if (r == 0) off = off + 32'($urandom_range(1, 3));
        else if (r == 1) off = 32'(depth_of(i) * 4 + 4 * $urandom_range(0, 7));
        a = base_of(i) + off;
        if (r == 2) a = base_of(i) - 32'(4 * $urandom_range(1, 4));
        txn(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
